// File: rtl/distance_loader.sv
// distance_loader: expands the host's strict upper-triangle distance stream
// into a full symmetric N x N table. It writes the diagonal zeros, each upper
// entry, and that entry's mirrored lower entry, in row-major order.
module distance_loader #(
    parameter int CITY_NUM     = 30,
    parameter int CITY_NUM_LOG = 5,
    parameter int DIST_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DIST_W-1:0]           s_data,
    output logic                        distance_write,
    output logic [2*CITY_NUM_LOG-1:0]   distance_w_addr,
    output logic [DIST_W-1:0]           distance_w_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIAG,
        S_UPPER,
        S_MIRROR,
        S_DONE
    } state_t;

    localparam logic [CITY_NUM_LOG-1:0] LAST = CITY_NUM_LOG'(CITY_NUM - 1);
    localparam logic [CITY_NUM_LOG-1:0] ONE  = CITY_NUM_LOG'(1);

    state_t                      r_state;
    logic [CITY_NUM_LOG-1:0]     r_i;
    logic [CITY_NUM_LOG-1:0]     r_j;
    logic [DIST_W-1:0]           r_hold;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_write;
    logic [2*CITY_NUM_LOG-1:0]   r_addr;
    logic [DIST_W-1:0]           r_data;

    state_t                      w_state_nxt;
    logic [CITY_NUM_LOG-1:0]     w_i_nxt;
    logic [CITY_NUM_LOG-1:0]     w_j_nxt;
    logic [DIST_W-1:0]           w_hold_nxt;
    logic                        w_done_nxt;
    logic                        w_write_nxt;
    logic [2*CITY_NUM_LOG-1:0]   w_addr_nxt;
    logic [DIST_W-1:0]           w_data_nxt;
    logic                        w_ready;

    // The host is only offered a slot in UPPER; the handshake never feeds back into s_ready.
    assign w_ready = (r_state == S_UPPER);

    // Next-state, counter and write-port decisions for the coming cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_hold_nxt  = r_hold;
        w_done_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_addr_nxt  = '0;
        w_data_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = '0;
                    w_data_nxt  = '0;
                    w_i_nxt     = '0;
                    w_j_nxt     = ONE;
                    w_state_nxt = S_UPPER;
                end
            end
            S_UPPER: begin
                if (s_valid) begin
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = {r_i, r_j};
                    w_data_nxt  = s_data;
                    w_hold_nxt  = s_data;
                    w_state_nxt = S_MIRROR;
                end
            end
            S_MIRROR: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = {r_j, r_i};
                w_data_nxt  = r_hold;
                if (r_j < LAST) begin
                    w_j_nxt     = r_j + ONE;
                    w_state_nxt = S_UPPER;
                end else begin
                    w_i_nxt     = r_i + ONE;
                    w_state_nxt = S_DIAG;
                end
            end
            S_DIAG: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = {r_i, r_i};
                w_data_nxt  = '0;
                if (r_i < LAST) begin
                    w_j_nxt     = r_i + ONE;
                    w_state_nxt = S_UPPER;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters, hold register and registered outputs; async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_hold  <= w_hold_nxt;
            // busy covers every cycle up to the one carrying the last write;
            // it drops when the FSM heads back to IDLE, i.e. in the done cycle
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_write <= w_write_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign s_ready         = w_ready;
    assign busy            = r_busy;
    assign done            = r_done;
    assign distance_write  = r_write;
    assign distance_w_addr = r_addr;
    assign distance_w_data = r_data;

endmodule

// File: tb/tb_distance_loader.sv
// Scoreboard bench for distance_loader: a 4-city and a 2-city instance.
// Expected writes are pushed when a load is started; monitors pop and compare.
module tb_distance_loader;

    localparam int L  = 5;
    localparam int DW = 16;
    localparam int AW = 2 * L;

    // Hand-computed N=4 write order for host words 11..16
    localparam int EXP_R [16] = '{0, 0, 1, 0, 2, 0, 3, 1, 1, 2, 1, 3, 2, 2, 3, 3};
    localparam int EXP_C [16] = '{0, 1, 0, 2, 0, 3, 0, 1, 2, 1, 3, 1, 2, 3, 2, 3};
    localparam int EXP_D [16] = '{0, 11, 11, 12, 12, 13, 13, 0, 14, 14, 15, 15, 0, 16, 16, 0};
    localparam int W4    [6]  = '{11, 12, 13, 14, 15, 16};

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          start4 = 1'b0, valid4 = 1'b0;
    logic [DW-1:0] data4 = '0;
    logic          busy4, done4, ready4, wr4;
    logic [AW-1:0] addr4;
    logic [DW-1:0] wdata4;

    logic          start2 = 1'b0, valid2 = 1'b0;
    logic [DW-1:0] data2 = '0;
    logic          busy2, done2, ready2, wr2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata2;

    wr_t q4[$];
    wr_t q2[$];
    wr_t e4, e2;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt4 = 0, gap_cnt4 = 0, done_cnt4 = 0;
    int wr_cnt2 = 0, done_cnt2 = 0;
    logic prev_wr4 = 1'b0, prev_wr2 = 1'b0;

    distance_loader #(.CITY_NUM(4), .CITY_NUM_LOG(L), .DIST_W(DW)) u_dut4 (
        .clk(clk), .reset(rst_n), .start(start4), .busy(busy4), .done(done4),
        .s_valid(valid4), .s_ready(ready4), .s_data(data4),
        .distance_write(wr4), .distance_w_addr(addr4), .distance_w_data(wdata4)
    );

    distance_loader #(.CITY_NUM(2), .CITY_NUM_LOG(L), .DIST_W(DW)) u_dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .busy(busy2), .done(done2),
        .s_valid(valid2), .s_ready(ready2), .s_data(data2),
        .distance_write(wr2), .distance_w_addr(addr2), .distance_w_data(wdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet4(input string tag);
        chk({tag, "_busy"},  32'(busy4),  32'd0);
        chk({tag, "_done"},  32'(done4),  32'd0);
        chk({tag, "_ready"}, 32'(ready4), 32'd0);
        chk({tag, "_write"}, 32'(wr4),    32'd0);
        chk({tag, "_addr"},  32'(addr4),  32'd0);
        chk({tag, "_data"},  32'(wdata4), 32'd0);
    endtask

    // Monitor for the 4-city instance: compare each write, count gaps and done pulses
    initial forever begin
        @(negedge clk);
        if (wr4) begin
            wr_cnt4++;
            chk("busy_on_write4", 32'(busy4), 32'd1);
            if (q4.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write4: actual addr=%0h data=%0h required no write", addr4, wdata4);
            end else begin
                e4 = q4.pop_front();
                chk("w_addr4", 32'(addr4),  32'(e4.addr));
                chk("w_data4", 32'(wdata4), 32'(e4.data));
            end
        end else if (busy4) begin
            gap_cnt4++;
        end
        if (done4) begin
            done_cnt4++;
            chk("done_busy4",       32'(busy4),    32'd0);
            chk("done_after_last4", 32'(prev_wr4), 32'd1);
        end
        prev_wr4 = wr4;
    end

    // Monitor for the 2-city instance
    initial forever begin
        @(negedge clk);
        if (wr2) begin
            wr_cnt2++;
            chk("busy_on_write2", 32'(busy2), 32'd1);
            if (q2.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write2: actual addr=%0h data=%0h required no write", addr2, wdata2);
            end else begin
                e2 = q2.pop_front();
                chk("w_addr2", 32'(addr2),  32'(e2.addr));
                chk("w_data2", 32'(wdata2), 32'(e2.data));
            end
        end
        if (done2) begin
            done_cnt2++;
            chk("done_busy2",       32'(busy2),    32'd0);
            chk("done_after_last2", 32'(prev_wr2), 32'd1);
        end
        prev_wr2 = wr2;
    end

    // One N=4 load. Inputs change 1 time unit after the falling edge.
    task automatic run4(input string tag, input int stall_idx, input int stall_len,
                        input int restart_at, input int reset_at, input int exp_gap);
        int  idx;
        int  stall;
        int  cyc;
        int  done_cyc;
        bit  hs;
        bit  restarted;
        wr_t e;
        @(negedge clk); #1;
        wr_cnt4 = 0; gap_cnt4 = 0; done_cnt4 = 0;
        q4.delete();
        for (int k = 0; k < 16; k++) begin
            e.addr = {L'(EXP_R[k]), L'(EXP_C[k])};
            e.data = DW'(EXP_D[k]);
            q4.push_back(e);
        end
        start4 = 1'b1;
        valid4 = 1'b1;
        data4  = DW'(W4[0]);
        @(negedge clk); #1;
        start4 = 1'b0;
        idx = 0; stall = stall_len; cyc = 1; done_cyc = 0; restarted = 1'b0;
        while (cyc < 60) begin
            if (done_cnt4 != 0 && done_cyc == 0) done_cyc = cyc;
            if (done_cyc != 0 && cyc > done_cyc + 3) break;
            if (reset_at > 0 && wr_cnt4 == reset_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk_quiet4({tag, "_after_reset"});
                chk({tag, "_writes_before_reset"}, 32'(wr_cnt4), 32'(reset_at));
                #1;
                rst_n = 1'b1;
                chk({tag, "_pending_dropped"}, 32'(q4.size()), 32'(16 - reset_at));
                q4.delete();
                repeat (4) @(negedge clk);
                #1;
                chk({tag, "_no_done"}, 32'(done_cnt4), 32'd0);
                return;
            end
            start4 = 1'b0;
            if (restart_at > 0 && !restarted && wr_cnt4 == restart_at) begin
                start4    = 1'b1;
                restarted = 1'b1;
            end
            if (ready4 && idx == stall_idx && stall > 0) begin
                valid4 = 1'b0;
                stall--;
            end else begin
                valid4 = 1'b1;
                data4  = (idx < 6) ? DW'(W4[idx]) : '0;
            end
            hs = ready4 && valid4;
            @(negedge clk); #1;
            cyc++;
            if (hs) idx++;
        end
        start4 = 1'b0;
        chk({tag, "_writes"},    32'(wr_cnt4),   32'd16);
        chk({tag, "_gaps"},      32'(gap_cnt4),  32'(exp_gap));
        chk({tag, "_done_cnt"},  32'(done_cnt4), 32'd1);
        chk({tag, "_done_cyc"},  32'(done_cyc),  32'(17 + exp_gap));
        chk({tag, "_words"},     32'(idx),       32'd6);
        chk({tag, "_sb_empty"},  32'(q4.size()), 32'd0);
    endtask

    initial begin
        int  cyc;
        int  done_cyc;
        wr_t e;

        // Reset, then idle with s_valid high and no start
        valid4 = 1'b1;
        valid2 = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet4("in_reset");
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk_quiet4("idle");
            chk("idle_write2", 32'(wr2), 32'd0);
        end

        run4("plain",   -1, 0, 0, 0, 0);
        run4("stall",    3, 3, 0, 0, 3);
        run4("restart", -1, 0, 5, 0, 0);
        run4("reset",   -1, 0, 0, 7, 0);
        run4("fresh",   -1, 0, 0, 0, 0);

        // N=2 boundary with an all-ones word
        @(negedge clk); #1;
        wr_cnt2 = 0; done_cnt2 = 0;
        e.addr = {L'(0), L'(0)}; e.data = 16'h0000; q2.push_back(e);
        e.addr = {L'(0), L'(1)}; e.data = 16'hFFFF; q2.push_back(e);
        e.addr = {L'(1), L'(0)}; e.data = 16'hFFFF; q2.push_back(e);
        e.addr = {L'(1), L'(1)}; e.data = 16'h0000; q2.push_back(e);
        start2 = 1'b1;
        valid2 = 1'b1;
        data2  = 16'hFFFF;
        @(negedge clk); #1;
        start2 = 1'b0;
        cyc = 1;
        done_cyc = 0;
        while (cyc < 20) begin
            if (done_cnt2 != 0 && done_cyc == 0) done_cyc = cyc;
            @(negedge clk); #1;
            cyc++;
        end
        chk("n2_writes",   32'(wr_cnt2),   32'd4);
        chk("n2_done_cnt", 32'(done_cnt2), 32'd1);
        chk("n2_done_cyc", 32'(done_cyc),  32'd5);
        chk("n2_sb_empty", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
